alu_issue_ctrl: RTL

Sequencing stage directly upstream of the ALU. Loads operand A (Y register) and operand B from the shared 32-bit datapath bus on consecutive cycles and drives opcode and operands to the ALU. Holds exec for the operation's settle time, then captures the LO/HI results into the ZLO/ZHI registers and pulses done. Gives the control unit a single start/done handshake per ALU operation, with multi-cycle settling for MUL/DIV.

---
 rtl/alu_issue_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequences operand loads from the shared bus into the ALU,
// holds alu_exec for the operation's settle time, captures LO/HI into
// zlo/zhi and pulses done (with err for operations that were not executed).
// Optional feature macro: ALU_DIVZERO_CHECK_EN (reject DIV with B == 0).
module alu_issue_ctrl #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULDIV_WAIT = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] bus_in,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_exec,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] alu_hi,
    output logic [WIDTH-1:0] zlo,
    output logic [WIDTH-1:0] zhi,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [3:0] OP_MUL   = 4'b1011;
    localparam logic [3:0] OP_DIV   = 4'b1100;
    localparam logic [3:0] WAIT_CNT = 4'(MULDIV_WAIT);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_B,
        EXEC,
        DONE
    } state_t;

    state_t           state, state_n;
    logic [3:0]       cnt, cnt_n;
    logic [3:0]       opcode_n;
    logic [WIDTH-1:0] a_n, b_n, zlo_n, zhi_n;
    logic             err_n;
    logic             is_muldiv;

    // State, operand, result and counter registers; everything clears asynchronously.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state      <= IDLE;
            cnt        <= '0;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            zlo        <= '0;
            zhi        <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            alu_opcode <= opcode_n;
            alu_a      <= a_n;
            alu_b      <= b_n;
            zlo        <= zlo_n;
            zhi        <= zhi_n;
            err        <= err_n;
        end
    end

    // Next-state, register next values and state-decoded outputs.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        opcode_n  = alu_opcode;
        a_n       = alu_a;
        b_n       = alu_b;
        zlo_n     = zlo;
        zhi_n     = zhi;
        err_n     = err;
        alu_exec  = 1'b0;
        busy      = (state != IDLE);
        done      = 1'b0;
        is_muldiv = (alu_opcode == OP_MUL) || (alu_opcode == OP_DIV);

        unique case (state)
            IDLE: begin
                if (start) begin
                    a_n      = bus_in;
                    opcode_n = op;
                    state_n  = LOAD_B;
                end
            end

            LOAD_B: begin
                // B is always loaded, even for unary ops where it is unused.
                b_n = bus_in;
                if (alu_opcode > OP_DIV) begin
                    err_n   = 1'b1;
                    state_n = DONE;
                end
`ifdef ALU_DIVZERO_CHECK_EN
                else if ((alu_opcode == OP_DIV) && (bus_in == '0)) begin
                    err_n   = 1'b1;
                    state_n = DONE;
                end
`endif
                else begin
                    err_n   = 1'b0;
                    cnt_n   = is_muldiv ? WAIT_CNT : '0;
                    state_n = EXEC;
                end
            end

            EXEC: begin
                alu_exec = 1'b1;
                if (cnt != '0) begin
                    cnt_n = cnt - 4'd1;
                end else begin
                    zlo_n = alu_result;
                    if (is_muldiv) begin
                        zhi_n = alu_hi;
                    end
                    state_n = DONE;
                end
            end

            DONE: begin
                done    = 1'b1;
                // err is only meaningful alongside done; drop it on the way out.
                err_n   = 1'b0;
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
